// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding selects, stall/flush controls and
// an optional multiply/divide busy tracker, compiled in only when HAZARD_MD_EN is defined.
module hazard_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       jumpD,
  input  logic       mdstartE,
  input  logic       mdopE,
  input  logic       mdaccessD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdbusy,
  output logic       mddone
);

  // $zero is hard-wired, so a write to it never produces a hazard.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  logic w_lwstall;
  logic w_branchstall;
  logic w_mdstall;
  logic w_stall;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM && reg_hit(writeregM, rsE))      forwardAE = 2'b10;
    else if (regwriteW && reg_hit(writeregW, rsE)) forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (regwriteM && reg_hit(writeregM, rtE))      forwardBE = 2'b10;
    else if (regwriteW && reg_hit(writeregW, rtE)) forwardBE = 2'b01;
  end

  assign forwardAD = regwriteM & reg_hit(writeregM, rsD);
  assign forwardBD = regwriteM & reg_hit(writeregM, rtD);

  assign w_lwstall     = memtoregE & (reg_hit(writeregE, rsD) | reg_hit(writeregE, rtD));
  assign w_branchstall = branchD &
                         ((regwriteE & (reg_hit(writeregE, rsD) | reg_hit(writeregE, rtD))) |
                          (memtoregM & (reg_hit(writeregM, rsD) | reg_hit(writeregM, rtD))));
  // HI/LO is written at the edge closing the done cycle, so the stall covers that cycle too.
  assign w_mdstall     = mdbusy & mdaccessD;
  assign w_stall       = w_lwstall | w_branchstall | w_mdstall;

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;
  // A stalled branch keeps its fetch slot until it resolves.
  assign flushD = (pcsrcD | jumpD) & ~w_stall;

`ifdef HAZARD_MD_EN
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_e     r_state;
  md_state_e     w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        if (mdstartE) begin
          w_state_next = ST_BUSY;
          w_count_next = mdopE ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_BUSY: begin
        if (r_count == '0) w_state_next = ST_IDLE;
        else               w_count_next = r_count - 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign mdbusy = (r_state == ST_BUSY);
  assign mddone = (r_state == ST_BUSY) && (r_count == '0);
`else
  // Tracker compiled out: HI/LO never appears busy and its controls are don't-cares.
  assign mdbusy = 1'b0;
  assign mddone = 1'b0;

  logic w_md_unused;
  assign w_md_unused = ^{clk, reset, mdstartE, mdopE,
                         32'(MUL_CYCLES), 32'(DIV_CYCLES), 32'(CW)};
`endif

endmodule
